// File: rtl/core_pkg.sv
// Shared encodings and defaults for the core's writeback path.
package core_pkg;

    // Writeback source select encodings
    localparam logic [1:0] MEMTOREG_ALU  = 2'b00;
    localparam logic [1:0] MEMTOREG_MEM  = 2'b01;
    localparam logic [1:0] MEMTOREG_PC   = 2'b10;
    localparam logic [1:0] MEMTOREG_ZERO = 2'b11;

    // Architectural zero register; writes to it are never performed
    localparam int REG_ZERO = 0;

    localparam int DEF_LANES  = 2;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_W  = 5;

endpackage

// File: rtl/wb_lane_sel.sv
// Per-lane writeback source mux, purely combinational from WB-stage fields.
module wb_lane_sel
    import core_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int PC_W   = 8
) (
    input  logic [1:0]        memtoreg,
    input  logic [DATA_W-1:0] alu_res,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [PC_W-1:0]   pc_plus,
    output logic [DATA_W-1:0] wb_data
);

    // Select writeback data; PC+increment is zero-extended to data width
    always_comb begin
        wb_data = '0;
        case (memtoreg)
            MEMTOREG_ALU: wb_data = alu_res;
            MEMTOREG_MEM: wb_data = mem_rdata;
            MEMTOREG_PC:  wb_data = DATA_W'(pc_plus);
            default:      wb_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_wb_pipe_lanes.sv
// N-lane MEM/WB pipeline register with stall/flush/kill, x0 and
// same-bundle collision suppression, and a retired-instruction counter.
module mem_wb_pipe_lanes
    import core_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int DATA_W = DEF_DATA_W,
    parameter int PC_W   = 8,
    parameter int REG_W  = DEF_REG_W,
    parameter int CNT_W  = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall_i,
    input  logic                    flush_i,
    input  logic [LANES-1:0]        lane_valid_i,
    input  logic [LANES-1:0]        lane_kill_i,
    input  logic [LANES*PC_W-1:0]   pc_plus_i,
    input  logic [LANES*DATA_W-1:0] mem_rdata_i,
    input  logic [LANES*DATA_W-1:0] alu_res_i,
    input  logic [LANES*REG_W-1:0]  dest_i,
    input  logic [LANES*2-1:0]      memtoreg_i,
    input  logic [LANES-1:0]        regwrite_i,
    output logic [LANES-1:0]        valid_o,
    output logic [LANES*REG_W-1:0]  dest_o,
    output logic [LANES-1:0]        regwrite_o,
    output logic [LANES*DATA_W-1:0] wb_data_o,
    output logic [CNT_W-1:0]        retire_cnt_o
);

    typedef struct packed {
        logic [1:0]        memtoreg;
        logic [REG_W-1:0]  dest;
        logic [PC_W-1:0]   pc_plus;
        logic [DATA_W-1:0] mem_rdata;
        logic [DATA_W-1:0] alu_res;
    } lane_t;

    lane_t [LANES-1:0]       lane_in;
    lane_t [LANES-1:0]       lane_q;
    logic  [LANES-1:0]       v;
    logic  [LANES-1:0]       collide;
    logic  [LANES-1:0]       rw_nxt;
    logic  [LANES-1:0]       valid_q;
    logic  [LANES-1:0]       rw_q;
    logic  [CNT_W-1:0]       retire_inc;
    logic  [CNT_W-1:0]       cnt_q;

    assign v = lane_valid_i & ~lane_kill_i;

    // An older lane loses its write if any younger live writer targets the same non-zero register
    always_comb begin
        collide = '0;
        for (int i = 0; i < LANES; i++) begin
            for (int j = 0; j < LANES; j++) begin
                if (j > i && v[j] && regwrite_i[j] &&
                    lane_in[j].dest == lane_in[i].dest &&
                    lane_in[i].dest != REG_W'(REG_ZERO))
                    collide[i] = 1'b1;
            end
        end
    end

    // Sanitised write enable and count of lanes retiring this edge
    always_comb begin
        rw_nxt     = '0;
        retire_inc = '0;
        for (int i = 0; i < LANES; i++) begin
            rw_nxt[i]  = regwrite_i[i] & v[i] & ~collide[i] &
                         (lane_in[i].dest != REG_W'(REG_ZERO));
            retire_inc = retire_inc + CNT_W'(v[i]);
        end
    end

    // WB register: flush beats stall beats capture; flush lets data load since it is don't-care
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane_q  <= '0;
            valid_q <= '0;
            rw_q    <= '0;
            cnt_q   <= '0;
        end else if (flush_i) begin
            lane_q  <= lane_in;
            valid_q <= '0;
            rw_q    <= '0;
        end else if (!stall_i) begin
            lane_q  <= lane_in;
            valid_q <= v;
            rw_q    <= rw_nxt;
            cnt_q   <= cnt_q + retire_inc;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_in[g].memtoreg  = memtoreg_i[g*2 +: 2];
        assign lane_in[g].dest      = dest_i[g*REG_W +: REG_W];
        assign lane_in[g].pc_plus   = pc_plus_i[g*PC_W +: PC_W];
        assign lane_in[g].mem_rdata = mem_rdata_i[g*DATA_W +: DATA_W];
        assign lane_in[g].alu_res   = alu_res_i[g*DATA_W +: DATA_W];

        assign dest_o[g*REG_W +: REG_W] = lane_q[g].dest;

        wb_lane_sel #(
            .DATA_W (DATA_W),
            .PC_W   (PC_W)
        ) u_sel (
            .memtoreg  (lane_q[g].memtoreg),
            .alu_res   (lane_q[g].alu_res),
            .mem_rdata (lane_q[g].mem_rdata),
            .pc_plus   (lane_q[g].pc_plus),
            .wb_data   (wb_data_o[g*DATA_W +: DATA_W])
        );
    end

    assign valid_o      = valid_q;
    assign regwrite_o   = rw_q;
    assign retire_cnt_o = cnt_q;

endmodule

// File: tb/tb_mem_wb_pipe_lanes.sv
// Self-checking bench: directed plan checks plus randomized traffic
// compared every cycle against a bundle-level behavioural model.
module tb_mem_wb_pipe_lanes;

    localparam int LANES = 2, DATA_W = 32, PC_W = 8, REG_W = 5, CNT_W = 4;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    stall_i = 1'b0, flush_i = 1'b0;
    logic [LANES-1:0]        lane_valid_i = '0, lane_kill_i = '0, regwrite_i = '0;
    logic [LANES*PC_W-1:0]   pc_plus_i = '0;
    logic [LANES*DATA_W-1:0] mem_rdata_i = '0, alu_res_i = '0;
    logic [LANES*REG_W-1:0]  dest_i = '0;
    logic [LANES*2-1:0]      memtoreg_i = '0;
    logic [LANES-1:0]        valid_o, regwrite_o;
    logic [LANES*REG_W-1:0]  dest_o;
    logic [LANES*DATA_W-1:0] wb_data_o;
    logic [CNT_W-1:0]        retire_cnt_o;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    mem_wb_pipe_lanes #(.LANES(LANES), .DATA_W(DATA_W), .PC_W(PC_W),
                        .REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
        .lane_valid_i(lane_valid_i), .lane_kill_i(lane_kill_i),
        .pc_plus_i(pc_plus_i), .mem_rdata_i(mem_rdata_i), .alu_res_i(alu_res_i),
        .dest_i(dest_i), .memtoreg_i(memtoreg_i), .regwrite_i(regwrite_i),
        .valid_o(valid_o), .dest_o(dest_o), .regwrite_o(regwrite_o),
        .wb_data_o(wb_data_o), .retire_cnt_o(retire_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Writers are resolved per register: walking from the youngest lane,
    // the first live writer of each non-zero register keeps its write.
    function automatic logic [LANES-1:0] model_rw(input logic [LANES-1:0] live,
                                                  input logic [LANES-1:0] rw,
                                                  input logic [LANES*REG_W-1:0] d);
        logic [31:0] claimed = '0;
        logic [LANES-1:0] res = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
            int r = int'(d[l*REG_W +: REG_W]);
            if (live[l] && rw[l] && r != 0 && !claimed[r]) begin
                res[l]     = 1'b1;
                claimed[r] = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic logic [DATA_W-1:0] model_wb(input logic [1:0] sel, input logic [DATA_W-1:0] alu,
                                                   input logic [DATA_W-1:0] mem, input logic [PC_W-1:0] pc);
        case (sel)
            2'd0:    return alu;
            2'd1:    return mem;
            2'd2:    return {{(DATA_W-PC_W){1'b0}}, pc};
            default: return '0;
        endcase
    endfunction

    logic [LANES-1:0]        m_valid = '0, m_rw = '0;
    logic [LANES*REG_W-1:0]  m_dest = '0;
    logic [LANES*DATA_W-1:0] m_wb = '0;
    int                      m_cnt = 0;
    bit                      m_known = 1'b1;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid <= '0; m_rw <= '0; m_dest <= '0; m_wb <= '0;
            m_cnt <= 0; m_known <= 1'b1;
        end else if (flush_i) begin
            m_valid <= '0; m_rw <= '0; m_known <= 1'b0;
        end else if (!stall_i) begin
            logic [LANES*DATA_W-1:0] wb;
            logic [LANES-1:0]        live;
            live = lane_valid_i & ~lane_kill_i;
            for (int l = 0; l < LANES; l++)
                wb[l*DATA_W +: DATA_W] = model_wb(memtoreg_i[l*2 +: 2], alu_res_i[l*DATA_W +: DATA_W],
                                                  mem_rdata_i[l*DATA_W +: DATA_W], pc_plus_i[l*PC_W +: PC_W]);
            m_valid <= live;
            m_rw    <= model_rw(live, regwrite_i, dest_i);
            m_dest  <= dest_i;
            m_wb    <= wb;
            m_cnt   <= (m_cnt + $countones(live)) % (1 << CNT_W);
            m_known <= 1'b1;
        end
    end

    // Compare every cycle away from the active edge
    always @(negedge clk) begin
        if (cmp_en) begin
            check("valid_o", 64'(valid_o), 64'(m_valid));
            check("regwrite_o", 64'(regwrite_o), 64'(m_rw));
            check("retire_cnt_o", 64'(retire_cnt_o), 64'(m_cnt));
            if (m_known) begin
                check("dest_o", 64'(dest_o), 64'(m_dest));
                check("wb_data_o", 64'(wb_data_o), 64'(m_wb));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic clear_in();
        lane_valid_i = '0; lane_kill_i = '0; regwrite_i = '0; memtoreg_i = '0;
        pc_plus_i = '0; mem_rdata_i = '0; alu_res_i = '0; dest_i = '0;
        stall_i = 1'b0; flush_i = 1'b0;
    endtask

    task automatic set_lane(input int l, input bit vld, input logic [1:0] sel, input logic [REG_W-1:0] d,
                            input bit rw, input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] mem,
                            input logic [PC_W-1:0] pc);
        lane_valid_i[l] = vld;
        memtoreg_i[l*2 +: 2] = sel;
        dest_i[l*REG_W +: REG_W] = d;
        regwrite_i[l] = rw;
        alu_res_i[l*DATA_W +: DATA_W] = alu;
        mem_rdata_i[l*DATA_W +: DATA_W] = mem;
        pc_plus_i[l*PC_W +: PC_W] = pc;
    endtask

    task automatic randomize_in();
        lane_valid_i = LANES'($urandom);
        lane_kill_i  = LANES'($urandom_range(0, 3) == 0 ? $urandom : 0);
        regwrite_i   = LANES'($urandom);
        memtoreg_i   = (LANES*2)'($urandom);
        pc_plus_i    = (LANES*PC_W)'($urandom);
        mem_rdata_i  = {$urandom, $urandom};
        alu_res_i    = {$urandom, $urandom};
        for (int l = 0; l < LANES; l++)
            dest_i[l*REG_W +: REG_W] = REG_W'($urandom_range(0, 3));
    endtask

    task automatic edge_then_settle();
        @(posedge clk); #1;
    endtask

    initial begin
        #3 reset = 1'b0;
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        cmp_en = 1'b1;

        // Reset mid-cycle with state and inputs nonzero
        lane_valid_i = '1; regwrite_i = '1; memtoreg_i = '1;
        dest_i = {5'd6, 5'd7}; alu_res_i = {32'h5, 32'h6}; stall_i = 1'b0;
        memtoreg_i = '0;
        @(posedge clk); @(posedge clk);
        memtoreg_i = '1; pc_plus_i = '1; mem_rdata_i = '1;
        #2 reset = 1'b0;
        #1;
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_regwrite", 64'(regwrite_o), 64'd0);
        check("rst_dest", 64'(dest_o), 64'd0);
        check("rst_wb", 64'(wb_data_o), 64'd0);
        check("rst_cnt", 64'(retire_cnt_o), 64'd0);

        // Basic capture, applied as reset releases
        @(negedge clk);
        clear_in();
        set_lane(0, 1, 2'b00, 5'd3, 1, 32'h11, 32'h0, 8'h0);
        set_lane(1, 1, 2'b01, 5'd4, 1, 32'h0, 32'hABCD, 8'h0);
        reset = 1'b1;
        edge_then_settle();
        check("basic_wb", 64'(wb_data_o), {32'hABCD, 32'h11});
        check("basic_rw", 64'(regwrite_o), 64'b11);
        check("basic_cnt", 64'(retire_cnt_o), 64'd2);

        // Same-bundle collision: youngest writer wins
        @(negedge clk);
        set_lane(0, 1, 2'b00, 5'd7, 1, 32'h1, 32'h0, 8'h0);
        set_lane(1, 1, 2'b00, 5'd7, 1, 32'h2, 32'h0, 8'h0);
        edge_then_settle();
        check("collide_rw", 64'(regwrite_o), 64'b10);
        check("collide_cnt", 64'(retire_cnt_o), 64'd4);

        // x0 destination suppressed but lane still valid
        @(negedge clk);
        set_lane(0, 1, 2'b00, 5'd0, 1, 32'h1, 32'h0, 8'h0);
        set_lane(1, 1, 2'b00, 5'd5, 1, 32'h2, 32'h0, 8'h0);
        edge_then_settle();
        check("x0_rw", 64'(regwrite_o), 64'b10);
        check("x0_valid", 64'(valid_o), 64'b11);

        // Stall holds everything for 3 cycles while inputs change
        @(negedge clk);
        set_lane(0, 1, 2'b00, 5'd9, 1, 32'h22, 32'h0, 8'h0);
        set_lane(1, 1, 2'b00, 5'd10, 1, 32'h33, 32'h0, 8'h0);
        edge_then_settle();
        check("pre_stall_cnt", 64'(retire_cnt_o), 64'd8);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            randomize_in();
            lane_kill_i = '1;
            stall_i = 1'b1;
            edge_then_settle();
            check("stall_wb", 64'(wb_data_o), {32'h33, 32'h22});
            check("stall_rw", 64'(regwrite_o), 64'b11);
            check("stall_cnt", 64'(retire_cnt_o), 64'd8);
        end
        @(negedge clk);
        flush_i = 1'b1;
        edge_then_settle();
        check("flush_valid", 64'(valid_o), 64'd0);
        check("flush_rw", 64'(regwrite_o), 64'd0);
        check("flush_cnt", 64'(retire_cnt_o), 64'd8);

        // Per-lane kill
        @(negedge clk);
        clear_in();
        set_lane(0, 1, 2'b00, 5'd1, 1, 32'h1, 32'h0, 8'h0);
        set_lane(1, 1, 2'b00, 5'd2, 1, 32'h2, 32'h0, 8'h0);
        lane_kill_i = 2'b01;
        edge_then_settle();
        check("kill_valid", 64'(valid_o), 64'b10);
        check("kill_cnt", 64'(retire_cnt_o), 64'd9);

        // PC path
        @(negedge clk);
        clear_in();
        set_lane(0, 1, 2'b10, 5'd1, 1, 32'hDEAD, 32'hBEEF, 8'hF2);
        edge_then_settle();
        check("pc_wb", 64'(wb_data_o[31:0]), 64'h0000_00F2);
        check("pc_cnt", 64'(retire_cnt_o), 64'd10);

        // Drive counter to 15 then wrap with one more valid lane
        @(negedge clk); lane_valid_i = 2'b11; edge_then_settle();
        @(negedge clk); lane_valid_i = 2'b11; edge_then_settle();
        @(negedge clk); lane_valid_i = 2'b01; edge_then_settle();
        check("cnt_15", 64'(retire_cnt_o), 64'd15);
        @(negedge clk); lane_valid_i = 2'b10; edge_then_settle();
        check("cnt_wrap", 64'(retire_cnt_o), 64'd0);

        // Kill together with flush: flush wins
        @(negedge clk);
        lane_valid_i = 2'b11; lane_kill_i = 2'b01; flush_i = 1'b1;
        edge_then_settle();
        check("killflush_valid", 64'(valid_o), 64'd0);
        check("killflush_cnt", 64'(retire_cnt_o), 64'd0);

        // Randomized traffic with one asynchronous reset in the middle
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            randomize_in();
            flush_i = ($urandom_range(0, 9) == 0);
            stall_i = ($urandom_range(0, 4) == 0);
            if (n == 200) begin
                @(posedge clk); #3 reset = 1'b0; #1;
                check("rnd_rst_cnt", 64'(retire_cnt_o), 64'd0);
                @(negedge clk); reset = 1'b1;
            end
        end
        @(negedge clk);
        clear_in();
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
